// File: rtl/tube_pkg.sv
// Shared definitions for the Tube parasite-side interrupt logic.
// Channel indices, NMI FSM encoding, default IRQ mask and the priority helper.
package tube_pkg;

  localparam logic [1:0] CH_R1 = 2'd0;
  localparam logic [1:0] CH_R2 = 2'd1;
  localparam logic [1:0] CH_R3 = 2'd2;
  localparam logic [1:0] CH_R4 = 2'd3;

  localparam logic [3:0] IRQ_MASK_DEFAULT = 4'b1001;

  typedef enum logic [1:0] {
    NMI_IDLE  = 2'b00,
    NMI_PULSE = 2'b01,
    NMI_WAIT  = 2'b10
  } nmi_state_e;

  // Highest-numbered pending channel wins; result is don't-care when nothing is pending.
  function automatic logic [1:0] prio_idx(input logic [3:0] pend);
    logic [1:0] idx;
    if (pend[3]) begin
      idx = CH_R4;
    end else if (pend[2]) begin
      idx = CH_R3;
    end else if (pend[1]) begin
      idx = CH_R2;
    end else begin
      idx = CH_R1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/tube_p2_int_ctrl_nmi.sv
// Edge-triggered NMI pulse generator: one NMI_WIDTH-cycle low pulse per rising
// edge of cond, re-armed only after cond has been sampled low.
module tube_nmi_pulse
  import tube_pkg::*;
#(
  parameter int NMI_WIDTH = 4
) (
  input  logic p2_clk,
  input  logic rst_b,
  input  logic cond,
  output logic nmi_n
);

  localparam logic [3:0] CNT_INIT = 4'(NMI_WIDTH - 1);

  if ((NMI_WIDTH < 1) || (NMI_WIDTH > 15)) begin : g_bad_width
    $error("tube_nmi_pulse: NMI_WIDTH must be in 1..15");
  end

  nmi_state_e state_r, state_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic       nmi_n_nxt_s;

  // State, width counter and output register; reset releases NMI at once.
  always_ff @(posedge p2_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= NMI_IDLE;
      cnt_r   <= 4'd0;
      nmi_n   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      nmi_n   <= nmi_n_nxt_s;
    end
  end

  // Output is decoded from the next state so the pulse starts on the entry edge.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    nmi_n_nxt_s = 1'b1;
    case (state_r)
      NMI_IDLE: begin
        if (cond) begin
          state_nxt_s = NMI_PULSE;
          cnt_nxt_s   = CNT_INIT;
          nmi_n_nxt_s = 1'b0;
        end else begin
          state_nxt_s = NMI_IDLE;
        end
      end
      NMI_PULSE: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = NMI_WAIT;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
          nmi_n_nxt_s = 1'b0;
        end
      end
      NMI_WAIT: begin
        if (!cond) begin
          state_nxt_s = NMI_IDLE;
        end else begin
          state_nxt_s = NMI_WAIT;
        end
      end
      default: begin
        state_nxt_s = NMI_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/tube_p2_int_ctrl.sv
// Parasite-side Tube interrupt controller: level IRQ with priority vector latch
// and stuck-IRQ timeout, plus edge-triggered NMI via tube_nmi_pulse.
module tube_p2_int_ctrl
  import tube_pkg::*;
#(
  parameter logic [3:0] IRQ_MASK  = IRQ_MASK_DEFAULT,
  parameter int         NMI_CH    = 2,
  parameter int         NMI_WIDTH = 4,
  parameter int         TIMEOUT_W = 16
) (
  input  logic       rst_b,
  input  logic       p2_clk,
  input  logic [3:0] ch_avail,
  input  logic [3:0] irq_en,
  input  logic       nmi_en,
  input  logic       p2_iack,
  input  logic       stuck_clr,
  output logic       p2_irq_n,
  output logic       p2_nmi_n,
  output logic [1:0] irq_vec,
  output logic       irq_spurious,
  output logic       irq_stuck
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

  if (IRQ_MASK[NMI_CH]) begin : g_bad_cfg
    $error("tube_p2_int_ctrl: NMI_CH must not be set in IRQ_MASK");
  end

  logic [3:0]           pend_s;
  logic                 any_pend_s;
  logic                 cond_s;
  logic [TIMEOUT_W-1:0] cnt_r, cnt_nxt_s;
  logic                 sat_s;

  assign pend_s     = ch_avail & irq_en & IRQ_MASK;
  assign any_pend_s = |pend_s;
  assign cond_s     = ch_avail[NMI_CH] & nmi_en;

  // IRQ level, acknowledge vector and spurious-ack pulse.
  always_ff @(posedge p2_clk or negedge rst_b) begin
    if (!rst_b) begin
      p2_irq_n     <= 1'b1;
      irq_vec      <= 2'd0;
      irq_spurious <= 1'b0;
    end else begin
      p2_irq_n     <= !any_pend_s;
      irq_spurious <= p2_iack & !any_pend_s;
      if (p2_iack && any_pend_s) begin
        irq_vec <= prio_idx(pend_s);
      end
    end
  end

  // Counter follows the registered IRQ line, so it measures what the CPU actually sees.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (p2_irq_n) begin
      cnt_nxt_s = {TIMEOUT_W{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = CNT_MAX;
    end else begin
      cnt_nxt_s = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
    sat_s = (cnt_nxt_s == CNT_MAX);
  end

  // Timeout counter and sticky flag; saturation outranks a simultaneous clear.
  always_ff @(posedge p2_clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_r     <= {TIMEOUT_W{1'b0}};
      irq_stuck <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (sat_s) begin
        irq_stuck <= 1'b1;
      end else if (stuck_clr) begin
        irq_stuck <= 1'b0;
      end
    end
  end

  tube_nmi_pulse #(
    .NMI_WIDTH (NMI_WIDTH)
  ) u_nmi (
    .p2_clk (p2_clk),
    .rst_b  (rst_b),
    .cond   (cond_s),
    .nmi_n  (p2_nmi_n)
  );

endmodule

// File: tb/tb_tube_p2_int_ctrl.sv
// Directed self-checking bench for tube_p2_int_ctrl (TIMEOUT_W shrunk to 4).
module tb_tube_p2_int_ctrl;

  logic       rst_b;
  logic       p2_clk;
  logic [3:0] ch_avail;
  logic [3:0] irq_en;
  logic       nmi_en;
  logic       p2_iack;
  logic       stuck_clr;
  logic       p2_irq_n;
  logic       p2_nmi_n;
  logic [1:0] irq_vec;
  logic       irq_spurious;
  logic       irq_stuck;

  int total;
  int bad;

  tube_p2_int_ctrl #(
    .TIMEOUT_W (4)
  ) dut (
    .rst_b        (rst_b),
    .p2_clk       (p2_clk),
    .ch_avail     (ch_avail),
    .irq_en       (irq_en),
    .nmi_en       (nmi_en),
    .p2_iack      (p2_iack),
    .stuck_clr    (stuck_clr),
    .p2_irq_n     (p2_irq_n),
    .p2_nmi_n     (p2_nmi_n),
    .irq_vec      (irq_vec),
    .irq_spurious (irq_spurious),
    .irq_stuck    (irq_stuck)
  );

  initial p2_clk = 1'b0;
  always #5 p2_clk = ~p2_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock, then settle 1 time unit past the edge.
  task automatic step();
    @(posedge p2_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b     = 1'b0;
    ch_avail  = 4'd0;
    irq_en    = 4'd0;
    nmi_en    = 1'b0;
    p2_iack   = 1'b0;
    stuck_clr = 1'b0;
    step();
    step();
    rst_b = 1'b1;
    step();
  endtask

  // Steps n cycles counting NMI-low cycles and the first low step (0 = none).
  task automatic count_nmi(input int n, output int lows, output int first);
    lows  = 0;
    first = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (!p2_nmi_n) begin
        lows = lows + 1;
        if (first == 0) first = k;
      end
    end
  endtask

  int lows;
  int first;
  int lows2;
  int first2;

  initial begin
    total = 0;
    bad   = 0;
    do_reset();
    check("rst_irq_n", 32'(p2_irq_n), 32'd1);
    check("rst_nmi_n", 32'(p2_nmi_n), 32'd1);
    check("rst_vec", 32'(irq_vec), 32'd0);
    check("rst_spur", 32'(irq_spurious), 32'd0);
    check("rst_stuck", 32'(irq_stuck), 32'd0);

    // R4 IRQ path
    irq_en   = 4'b1001;
    ch_avail = 4'b1000;
    #1;
    check("irq_before_edge", 32'(p2_irq_n), 32'd1);
    step();
    check("r4_irq_low", 32'(p2_irq_n), 32'd0);
    p2_iack = 1'b1;
    step();
    p2_iack = 1'b0;
    check("r4_vec", 32'(irq_vec), 32'd3);
    check("r4_no_spur", 32'(irq_spurious), 32'd0);
    ch_avail = 4'b0000;
    step();
    check("r4_irq_high", 32'(p2_irq_n), 32'd1);

    // Priority and spurious
    ch_avail = 4'b1001;
    p2_iack  = 1'b1;
    step();
    check("prio_vec_r4", 32'(irq_vec), 32'd3);
    check("prio_irq_low", 32'(p2_irq_n), 32'd0);
    ch_avail = 4'b0001;
    step();
    check("prio_vec_r1", 32'(irq_vec), 32'd0);
    ch_avail = 4'b0000;
    step();
    p2_iack = 1'b0;
    check("spur_pulse", 32'(irq_spurious), 32'd1);
    check("spur_vec_hold0", 32'(irq_vec), 32'd0);
    step();
    check("spur_one_cycle", 32'(irq_spurious), 32'd0);
    ch_avail = 4'b1000;
    p2_iack  = 1'b1;
    step();
    ch_avail = 4'b0000;
    step();
    p2_iack = 1'b0;
    check("spur_vec_hold3", 32'(irq_vec), 32'd3);
    check("spur_pulse2", 32'(irq_spurious), 32'd1);
    ch_avail = 4'b0110;
    step();
    step();
    check("masked_irq_high", 32'(p2_irq_n), 32'd1);
    check("masked_nmi_off", 32'(p2_nmi_n), 32'd1);

    // NMI pulse, held condition, re-trigger
    ch_avail = 4'b0000;
    nmi_en   = 1'b1;
    step();
    ch_avail = 4'b0100;
    count_nmi(20, lows, first);
    check("nmi_lows", 32'(lows), 32'd4);
    check("nmi_first", 32'(first), 32'd1);
    ch_avail = 4'b0000;
    step();
    ch_avail = 4'b0100;
    count_nmi(10, lows, first);
    check("nmi2_lows", 32'(lows), 32'd4);
    check("nmi2_first", 32'(first), 32'd1);

    // nmi_en dropped in pulse cycle 2 does not truncate
    ch_avail = 4'b0000;
    step();
    step();
    ch_avail = 4'b0100;
    count_nmi(2, lows, first);
    nmi_en = 1'b0;
    count_nmi(6, lows2, first2);
    check("nmi_en_drop_lows", 32'(lows + lows2), 32'd4);
    check("nmi_en_drop_first", 32'(first), 32'd1);

    // Reset mid-pulse releases NMI without a clock
    nmi_en = 1'b1;
    ch_avail = 4'b0000;
    step();
    step();
    ch_avail = 4'b0100;
    count_nmi(2, lows, first);
    check("pre_rst_lows", 32'(lows), 32'd2);
    rst_b = 1'b0;
    #1;
    check("async_rst_nmi", 32'(p2_nmi_n), 32'd1);
    step();
    rst_b = 1'b1;
    count_nmi(8, lows, first);
    check("post_rst_lows", 32'(lows), 32'd4);
    check("post_rst_first", 32'(first), 32'd1);

    // Timeout with TIMEOUT_W=4
    do_reset();
    irq_en   = 4'b0001;
    ch_avail = 4'b0001;
    step();
    check("to_irq_low", 32'(p2_irq_n), 32'd0);
    for (int k = 0; k < 14; k++) step();
    check("to_not_yet", 32'(irq_stuck), 32'd0);
    step();
    check("to_stuck", 32'(irq_stuck), 32'd1);
    stuck_clr = 1'b1;
    step();
    stuck_clr = 1'b0;
    check("to_clr_while_sat", 32'(irq_stuck), 32'd1);
    step();
    check("to_sticky", 32'(irq_stuck), 32'd1);
    ch_avail = 4'b0000;
    step();
    check("to_irq_high", 32'(p2_irq_n), 32'd1);
    check("to_still_stuck", 32'(irq_stuck), 32'd1);
    stuck_clr = 1'b1;
    step();
    stuck_clr = 1'b0;
    check("to_cleared", 32'(irq_stuck), 32'd0);
    ch_avail = 4'b0001;
    step();
    for (int k = 0; k < 14; k++) step();
    check("to_cnt_restart", 32'(irq_stuck), 32'd0);
    step();
    check("to_stuck_again", 32'(irq_stuck), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
